// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bus field widths, arbiter state encoding and the
// 7-bit slave addresses of the devices on the board.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_DATA_W = 8;

  localparam logic [I2C_ADDR_W-1:0] TOUCH_ADDR  = 7'h38;
  localparam logic [I2C_ADDR_W-1:0] RTC_ADDR    = 7'h68;
  localparam logic [I2C_ADDR_W-1:0] EEPROM_ADDR = 7'h50;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGrant = 2'd1,
    StDrain = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder.
// Scans req upward starting at ptr, wrapping at NUM_REQ, and returns the
// first set bit as a one-hot vector plus its index.
//   req    in   NUM_REQ   candidate requests
//   ptr    in   ID_W      highest-priority position
//   oh     out  NUM_REQ   one-hot winner (0 when no request)
//   idx    out  ID_W      winner index (0 when no request)
//   valid  out  1         any request present
module rr_pick #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] oh,
  output logic [ID_W-1:0]    idx,
  output logic               valid
);

  always_comb begin
    oh    = '0;
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!valid && req[(32'(ptr) + i) % NUM_REQ]) begin
        valid                            = 1'b1;
        oh[(32'(ptr) + i) % NUM_REQ]     = 1'b1;
        idx                              = ID_W'((32'(ptr) + i) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one I2C master between NUM_REQ requesters. Round-robin grant held for
// a whole transaction; the owner's command fields are muxed to the master. A
// watchdog revokes the grant if the owner leaves the bus idle for TIMEOUT cycles.
//   clk, reset              clock, asynchronous active-low reset
//   req/req_en/req_rw       per-requester request level, command strobe, read/write
//   req_addr/req_data       packed 7-bit addresses / 8-bit write bytes
//   gnt/owner               one-hot registered grant and owner index
//   req_busy                busy as seen by each requester
//   timeout_err             one-cycle pulse on watchdog revocation
//   m_en/m_rw/m_addr/m_data command to master; m_busy from master
module i2c_bus_arbiter
  import i2c_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_en,
  input  logic [NUM_REQ-1:0]            req_rw,
  input  logic [I2C_ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [I2C_DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            req_busy,
  output logic [ID_W-1:0]               owner,
  output logic                          timeout_err,
  output logic                          m_en,
  output logic                          m_rw,
  output logic [I2C_ADDR_W-1:0]         m_addr,
  output logic [I2C_DATA_W-1:0]         m_data,
  input  logic                          m_busy
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  arb_state_t          state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                timeout_err_q, timeout_err_d;
  // Requesters revoked by the watchdog stay ineligible until they drop req.
  logic [NUM_REQ-1:0]  blocked_q, blocked_d;

  logic [NUM_REQ-1:0]  eligible;
  logic [NUM_REQ-1:0]  pick_oh;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_valid;
  logic [ID_W-1:0]     next_ptr;
  logic                owner_idle;

  assign eligible   = req & ~blocked_q;
  assign next_ptr   = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + ID_W'(1);
  assign owner_idle = !m_busy && !req_en[owner_q];

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req   (eligible),
    .ptr   (ptr_q),
    .oh    (pick_oh),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    owner_d       = owner_q;
    ptr_d         = ptr_q;
    wd_d          = '0;
    timeout_err_d = 1'b0;
    blocked_d     = blocked_q & req;
    case (state_q)
      StIdle: begin
        if (pick_valid && !m_busy) begin
          gnt_d   = pick_oh;
          owner_d = pick_idx;
          state_d = StGrant;
        end
      end
      StGrant: begin
        // A release wins over a coincident watchdog expiry.
        if (!req[owner_q]) begin
          gnt_d   = '0;
          ptr_d   = next_ptr;
          state_d = StDrain;
        end else if (owner_idle) begin
          if (wd_q >= WD_W'(TIMEOUT - 1)) begin
            gnt_d              = '0;
            ptr_d              = next_ptr;
            timeout_err_d      = 1'b1;
            blocked_d[owner_q] = 1'b1;
            state_d            = StDrain;
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
        end
      end
      StDrain: begin
        if (!m_busy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      gnt_q         <= '0;
      owner_q       <= '0;
      ptr_q         <= '0;
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
      blocked_q     <= '0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      owner_q       <= owner_d;
      ptr_q         <= ptr_d;
      wd_q          <= wd_d;
      timeout_err_q <= timeout_err_d;
      blocked_q     <= blocked_d;
    end
  end

  // Command mux: master sees all-zero commands whenever no grant is held.
  always_comb begin
    m_en   = 1'b0;
    m_rw   = 1'b0;
    m_addr = '0;
    m_data = '0;
    if (|gnt_q) begin
      m_en   = req_en[owner_q];
      m_rw   = req_rw[owner_q];
      m_addr = req_addr[32'(owner_q)*I2C_ADDR_W +: I2C_ADDR_W];
      m_data = req_data[32'(owner_q)*I2C_DATA_W +: I2C_DATA_W];
    end
  end

  always_comb begin
    req_busy = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) begin
        req_busy[i] = m_busy;
      end else if (|gnt_q || state_q != StIdle) begin
        req_busy[i] = 1'b1;
      end else begin
        req_busy[i] = m_busy;
      end
    end
  end

  assign gnt         = gnt_q;
  assign owner       = owner_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
module tb_i2c_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req, req_en, req_rw;
  logic [20:0] req_addr;
  logic [23:0] req_data;
  logic [2:0]  gnt, req_busy;
  logic [1:0]  owner;
  logic        timeout_err, m_en, m_rw, m_busy;
  logic [6:0]  m_addr;
  logic [7:0]  m_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2c_bus_arbiter #(
    .NUM_REQ (3),
    .ID_W    (2),
    .TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_en      (req_en),
    .req_rw      (req_rw),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .gnt         (gnt),
    .req_busy    (req_busy),
    .owner       (owner),
    .timeout_err (timeout_err),
    .m_en        (m_en),
    .m_rw        (m_rw),
    .m_addr      (m_addr),
    .m_data      (m_data),
    .m_busy      (m_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b0;
    req      = '0;
    req_en   = '0;
    req_rw   = '0;
    req_addr = {7'h50, 7'h68, 7'h38};
    req_data = {8'hC3, 8'hB2, 8'hA1};
    m_busy   = 1'b0;
    tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_terr", 32'(timeout_err), 32'h0);
    reset = 1'b1;

    // 1: idle after reset
    tick();
    chk("t1_gnt", 32'(gnt), 32'h0);
    chk("t1_m_en", 32'(m_en), 32'h0);
    chk("t1_busy", 32'(req_busy), 32'h0);

    // 2: single requester, 1-clk grant latency and command mux
    req = 3'b001;
    tick();
    chk("t2_gnt", 32'(gnt), 32'h1);
    chk("t2_owner", 32'(owner), 32'h0);
    req_en = 3'b011;  // en from non-owner 1 ignored
    req_rw = 3'b001;
    #1;
    chk("t2_m_en", 32'(m_en), 32'h1);
    chk("t2_m_addr", 32'(m_addr), 32'h38);
    chk("t2_m_data", 32'(m_data), 32'hA1);
    chk("t2_m_rw", 32'(m_rw), 32'h1);
    chk("t2_busy0", 32'(req_busy), 32'h6);
    m_busy = 1'b1;
    #1;
    chk("t2_busy1", 32'(req_busy), 32'h7);
    req = '0; req_en = '0; req_rw = '0; m_busy = 1'b0;
    tick();
    chk("t2_rel_gnt", 32'(gnt), 32'h0);
    chk("t2_rel_m_en", 32'(m_en), 32'h0);
    chk("t2_drain_busy", 32'(req_busy), 32'h7);
    tick();

    // 3: round-robin order from a fresh pointer
    reset = 1'b0; #1; reset = 1'b1;
    req = 3'b111;
    tick();
    chk("t3_g0", 32'(gnt), 32'h1);
    req = 3'b110; tick();
    req = 3'b111; tick();
    tick();
    chk("t3_g1", 32'(gnt), 32'h2);
    req = 3'b101; tick();
    req = 3'b111; tick();
    tick();
    chk("t3_g2", 32'(gnt), 32'h4);
    req = 3'b011; tick();
    req = 3'b111; tick();
    tick();
    chk("t3_g3", 32'(gnt), 32'h1);

    // 4: owner 1 releases during a transfer; drain until master idle
    req = 3'b110; tick();
    tick();
    tick();
    chk("t4_g1", 32'(gnt), 32'h2);
    m_busy = 1'b1; req_en = 3'b010;
    req = 3'b101;
    tick();
    chk("t4_drain_gnt", 32'(gnt), 32'h0);
    tick(); tick();
    chk("t4_hold_gnt", 32'(gnt), 32'h0);
    chk("t4_hold_m_en", 32'(m_en), 32'h0);
    m_busy = 1'b0; req_en = '0;
    tick();
    tick();
    chk("t4_next_gnt", 32'(gnt), 32'h4);
    chk("t4_next_owner", 32'(owner), 32'h2);

    // 5: watchdog with TIMEOUT=16
    repeat (15) tick();
    chk("t5_pre_gnt", 32'(gnt), 32'h4);
    chk("t5_pre_terr", 32'(timeout_err), 32'h0);
    tick();
    chk("t5_gnt", 32'(gnt), 32'h0);
    chk("t5_terr", 32'(timeout_err), 32'h1);
    tick();
    chk("t5_terr_off", 32'(timeout_err), 32'h0);
    tick();
    chk("t5_next_gnt", 32'(gnt), 32'h1);
    req = 3'b100; tick();  // req2 still held, still blocked
    tick();
    tick();
    chk("t5_blocked", 32'(gnt), 32'h0);
    req = 3'b000; tick();
    req = 3'b100; tick();
    chk("t5_unblock", 32'(gnt), 32'h4);

    // 6: reset mid-burst of owner 2
    req_en = 3'b100; m_busy = 1'b1;
    #1;
    chk("t6_m_en", 32'(m_en), 32'h1);
    chk("t6_m_addr", 32'(m_addr), 32'h50);
    reset = 1'b0;
    #1;
    chk("t6_rst_gnt", 32'(gnt), 32'h0);
    chk("t6_rst_m_en", 32'(m_en), 32'h0);
    req = 3'b101; req_en = '0; m_busy = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("t6_gnt", 32'(gnt), 32'h1);
    chk("t6_owner", 32'(owner), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
